// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio -- memory-mapped 8N1 UART receiver with a small receive FIFO.
//
// Deserializes the asynchronous serial line `rx` (idle high, LSB first) into
// bytes and queues them in a FIFO. The CPU reads them through two word
// registers decoded from the data-memory byte address bus:
//   BASE_ADDR     DATA   : {24'b0, FIFO head}, or 0 when empty; a read pops.
//   BASE_ADDR + 4 STATUS : {16'b0, count[7:0], 4'b0, PERR, FERR, OVR, valid};
//                          a read clears PERR/FERR/OVR.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one even-parity bit between data and stop (11-bit frame),
//                mismatches set PERR and drop the byte.
//   undefined -> plain 8N1, PERR (STATUS bit3) is constant 0.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4, even)
//   FIFO_DEPTH    receive FIFO entries (power of 2, >= 2)
//   BASE_ADDR     DATA register address; STATUS sits at BASE_ADDR + 4
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial input, idle high
//   addr[31:0] in   data-memory byte address
//   re         in   read strobe
//   dout[31:0] out  register read data, combinational from addr
//   rx_irq     out  high while the FIFO holds at least one byte
//   fsm_state  out  receiver state for debug/checkers
//                   (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BREAK)
//
// Bus strobe semantics: `re` is a one-cycle load strobe with no handshake.
// `dout` is valid in the same cycle as `addr`, and the side effect of the
// read (pop for DATA, flag clear for STATUS) takes place on the rising edge
// that ends the strobe cycle, so the returned value is the pre-effect value.
module uart_rx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [31:0] addr,
  input  logic        re,
  output logic [31:0] dout,
  output logic        rx_irq,
  output logic [2:0]  fsm_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer (resets to the idle level so reset never looks like a
  // start bit).
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          bit_tick;
  logic          push_req;
  logic          ferr_set;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr_set;
`endif

  // The counter is loaded with the cycles remaining until the next sample
  // point, so expiry is simply zero.
  assign bit_tick  = (cnt_q == '0);
  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_set  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_sync) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end
      end
      S_START: begin
        if (bit_tick) begin
          // Still low at mid start bit: a real frame. Otherwise a glitch.
          if (!rx_sync) begin
            state_d = S_DATA;
            cnt_d   = FULL_M1;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shreg_d = {rx_sync, shreg_q[7:1]};
          cnt_d   = FULL_M1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = ^{shreg_q, rx_sync};
          cnt_d     = FULL_M1;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) perr_set = 1'b1;
            else           push_req = 1'b1;
`else
            push_req = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            // Low stop bit: framing error or line break; wait for idle.
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_BREAK: begin
        if (rx_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic [AW:0] count;
  logic        empty, full;
  logic        sel_data, sel_stat;
  logic        pop, do_push, ovr_set, flag_clr;

  assign count    = wptr_q - rptr_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign sel_data = (addr == BASE_ADDR);
  assign sel_stat = (addr == STAT_ADDR);
  assign pop      = re && sel_data && !empty;
  assign flag_clr = re && sel_stat;
  // A pop on the same edge frees the slot the new byte needs.
  assign do_push  = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)     rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr_q[AW-1:0]] <= shreg_q;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new event on the clearing edge wins.
  // ---------------------------------------------------------------------------
  logic ovr_q, ferr_q, perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~flag_clr);
      ferr_q <= ferr_set | (ferr_q & ~flag_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_set | (perr_q & ~flag_clr);
  end
`else
  assign perr_q = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Register read mux
  // ---------------------------------------------------------------------------
  logic [7:0] count8;
  assign count8 = 8'(count);
  assign rx_irq = !empty;

  always_comb begin
    dout = '0;
    if (sel_data) begin
      if (!empty) dout = {24'b0, mem[rptr_q[AW-1:0]]};
    end else if (sel_stat) begin
      dout = {16'b0, count8, 4'b0, perr_q, ferr_q, ovr_q, !empty};
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Testbench for uart_rx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=8, default BASE_ADDR).
// A frame-level model predicts FIFO contents and sticky flags; every cycle
// after reset the register read data and rx_irq are compared against it.
// Directed literal checks pin the model at the interesting points.
module tb_uart_rx_mmio;

  localparam int          CPB    = 4;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] DATA_A = 32'h1000_0004;
  localparam logic [31:0] STAT_A = 32'h1000_0008;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edges from the last edge before the start bit is driven to the edge on
  // which the frame's outcome lands: two synchronizer edges plus the detect
  // edge, half a bit to mid start, then one bit period per remaining bit.
  localparam int LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

  localparam int EV_BYTE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;

  typedef struct {
    int unsigned due;
    logic [7:0]  b;
    int          kind;
  } ev_t;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [31:0] addr = STAT_A;
  logic        re = 1'b0;
  logic [31:0] dout;
  logic        rx_irq;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  uart_rx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (DATA_A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .addr     (addr),
    .re       (re),
    .dout     (dout),
    .rx_irq   (rx_irq),
    .fsm_state(fsm_state)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [7:0]  exp_q[$];
  ev_t         ev_q[$];
  logic        m_ovr, m_ferr, m_perr;
  int unsigned edge_count = 0;
  bit          model_ok = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_dout(input logic [31:0] a);
    logic [7:0] n = 8'(exp_q.size());
    logic       v = (exp_q.size() != 0);
    if (a == DATA_A) return v ? {24'b0, exp_q[0]} : 32'b0;
    if (a == STAT_A) return {16'b0, n, 4'b0, m_perr, m_ferr, m_ovr, v};
    return 32'b0;
  endfunction

  // Model update on every edge, using the bus inputs present at that edge.
  always @(posedge clk) begin
    bit  pop_now, clr_now, was_full;
    ev_t ev;
    edge_count++;
    if (rst) begin
      exp_q.delete();
      ev_q.delete();
      m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      model_ok = 1'b1;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      pop_now  = re && (addr == DATA_A) && (exp_q.size() != 0);
      clr_now  = re && (addr == STAT_A);
      if (clr_now) begin
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      end
      if (pop_now) void'(exp_q.pop_front());
      if (ev_q.size() != 0 && ev_q[0].due == edge_count) begin
        ev = ev_q.pop_front();
        case (ev.kind)
          EV_BYTE: begin
            if (!was_full || pop_now) exp_q.push_back(ev.b);
            else                      m_ovr = 1'b1;
          end
          EV_FERR: m_ferr = 1'b1;
          default: m_perr = 1'b1;
        endcase
      end
    end
  end

  // Compare process: outputs checked mid-cycle on every cycle after reset.
  always @(negedge clk) begin
    if (model_ok) begin
      check("dout_cycle", dout, exp_dout(addr));
      check("irq_cycle", {31'b0, rx_irq}, {31'b0, exp_q.size() != 0});
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      addr = i[0] ? STAT_A : DATA_A;
      re   = 1'b0;
      tick();
    end
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    re   = 1'b0;
    #1;
    check(name, dout, exp);
    tick();
  endtask

  task automatic read_reg(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    re   = 1'b1;
    #1;
    check(name, dout, exp);
    tick();
    re = 1'b0;
  endtask

  // Drives one frame on rx and records its expected outcome. Leaves rx at
  // the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip);
    ev_t ev;
    ev.due  = edge_count + LAT;
    ev.b    = b;
    ev.kind = stop_bit ? EV_BYTE : EV_FERR;
`ifdef UART_RX_PARITY_EN
    if (stop_bit && par_flip) ev.kind = EV_PERR;
`endif
    ev_q.push_back(ev);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) tick();
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_bit;
    repeat (CPB) tick();
  endtask

  // Issues a DATA read whose pop edge coincides with edge number `at`.
  task automatic read_at(input int unsigned at, input logic [31:0] exp, input string name);
    while (edge_count < at - 1) tick();
    read_reg(DATA_A, exp, name);
    addr = STAT_A;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int unsigned p;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_fsm_idle", {29'b0, fsm_state}, 32'd0);
    check("rst_irq", {31'b0, rx_irq}, 32'd0);
    peek(STAT_A, 32'h0, "rst_status");
    peek(DATA_A, 32'h0, "rst_data");
    idle(4);

    // Single byte
    send_frame(8'h41, 1'b1, 1'b0);
    idle(2);
    peek(STAT_A, 32'h0000_0101, "single_status");
    read_reg(DATA_A, 32'h0000_0041, "single_data");
    peek(STAT_A, 32'h0, "single_status_after");
    check("single_irq_low", {31'b0, rx_irq}, 32'd0);

    // Overrun: nine bytes into an eight-entry FIFO
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    idle(2);
    peek(STAT_A, 32'h0000_0803, "ovr_status");
    for (int i = 0; i < 8; i++) read_reg(DATA_A, 32'(i), "ovr_drain");
    read_reg(STAT_A, 32'h0000_0002, "ovr_status_read");
    peek(STAT_A, 32'h0, "ovr_cleared");

    // Full FIFO with a pop on the same edge as the ninth push
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
    p = edge_count + LAT;
    fork
      send_frame(8'h99, 1'b1, 1'b0);
      read_at(p, 32'h0000_0010, "simpop_head");
    join
    idle(2);
    peek(STAT_A, 32'h0000_0801, "simpop_status");
    for (int i = 1; i < 8; i++) read_reg(DATA_A, 32'(8'h10 + i), "simpop_drain");
    read_reg(DATA_A, 32'h0000_0099, "simpop_last");
    peek(STAT_A, 32'h0, "simpop_empty");

    // Read in the same cycle as a push into an empty FIFO: returns 0, no pop
    p = edge_count + LAT;
    fork
      send_frame(8'h7E, 1'b1, 1'b0);
      read_at(p, 32'h0, "empty_race_read");
    join
    idle(1);
    read_reg(DATA_A, 32'h0000_007E, "empty_race_data");

    // Frame error, line held low, then a clean byte
    send_frame(8'h55, 1'b0, 1'b0);
    idle(20);
    rx = 1'b1;
    idle(4);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2);
    peek(STAT_A, 32'h0000_0105, "ferr_status");
    read_reg(DATA_A, 32'h0000_00A5, "ferr_data");
    read_reg(STAT_A, 32'h0000_0004, "ferr_status_read");
    peek(STAT_A, 32'h0, "ferr_cleared");

    // One-cycle glitch
    rx = 1'b0;
    tick();
    rx = 1'b1;
    idle(10);
    check("glitch_fsm_idle", {29'b0, fsm_state}, 32'd0);
    peek(STAT_A, 32'h0, "glitch_status");

    // Reset in bit 3 of a frame, with a byte already buffered
    send_frame(8'h66, 1'b1, 1'b0);
    idle(2);
    peek(STAT_A, 32'h0000_0101, "pre_rst_status");
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1);
      repeat (CPB) tick();
    end
    rx = 1'b1;
    repeat (CPB / 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peek(STAT_A, 32'h0, "midrst_status");
    peek(DATA_A, 32'h0, "midrst_data");
    idle(20);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2);
    read_reg(DATA_A, 32'h0000_003C, "post_rst_byte");
    peek(STAT_A, 32'h0, "post_rst_status");

`ifdef UART_RX_PARITY_EN
    // Parity: good then bad parity on 0x03
    send_frame(8'h03, 1'b1, 1'b0);
    idle(2);
    read_reg(DATA_A, 32'h0000_0003, "par_ok_data");
    send_frame(8'h03, 1'b1, 1'b1);
    idle(2);
    peek(STAT_A, 32'h0000_0008, "perr_status");
    read_reg(STAT_A, 32'h0000_0008, "perr_status_read");
    peek(STAT_A, 32'h0, "perr_cleared");
`endif

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
